fetch_pc_gen: RTL and testbench
===============================

Name: fetch_pc_gen

Overview:
Fetch-stage PC sequencer that sits directly upstream of the per-PC two-bit saturating branch predictor and consumes its taken/not-taken output. It presents the current fetch PC to instruction memory and the predictor, and looks up a direct-mapped branch target buffer (BTB). It selects the next PC from the BTB hit, the predictor bit and the sequential PC, and hands each fetched PC plus its prediction bundle to the instruction queue over a valid/ready handshake. Redirects from branch resolution override everything.

Parameters:
PC_W, 32, fetch PC width in bits; low two bits are always zero.
BTB_ENTRIES, 16, BTB depth; power of two, at least 2. IDX_W = log2(BTB_ENTRIES).
RESET_PC, 32'h0000_0000, PC loaded on reset; low two bits are ignored and treated as zero.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
fetch_pc  output  PC_W  current fetch PC, driven to I-mem and the predictor index.
pred_taken  input  1  predictor output for fetch_pc, combinational in the same cycle.
fetch_valid  output  1  fetch_pc and the prediction bundle are valid.
fetch_ready  input  1  instruction queue accepts this cycle.
fetch_pred_taken  output  1  final prediction: btb_hit AND pred_taken.
fetch_pred_target  output  PC_W  predicted next PC sent with the instruction.
btb_wr_en  input  1  BTB write from branch resolution.
btb_wr_pc  input  PC_W  PC of the resolved taken branch.
btb_wr_target  input  PC_W  target of the resolved taken branch.
redirect  input  1  mispredict or flush request.
redirect_pc  input  PC_W  correct restart PC.
fetch_count  output  32  number of accepted fetches; wraps modulo 2^32.

Behaviour:
- Reset (async assert): pc = RESET_PC with bits [1:0] = 0, state = BOOT, all BTB valid bits = 0, fetch_count = 0.
- Outputs during reset: fetch_valid = 0, fetch_pred_taken = 0.
- The BTB tag/target arrays need no reset.
- States: BOOT, RUN, FLUSH.
- BOOT: fetch_valid = 0 for exactly one cycle after reset deasserts, then go to RUN.
- FLUSH: fetch_valid = 0 for one cycle after a redirect, then go to RUN.
- fetch_valid = (state == RUN) AND NOT redirect. This is combinational squash.
- BTB index = fetch_pc[IDX_W+1:2]; tag = fetch_pc[PC_W-1:IDX_W+2].
- btb_hit = entry valid AND tag match. The BTB read is combinational.
- fetch_pred_taken = btb_hit AND pred_taken.
- fetch_pred_target = fetch_pred_taken ? {btb_target[PC_W-1:2], 2'b00} : fetch_pc + 4.
- Sequential increment wraps modulo 2^PC_W.
- Next-PC priority at each rising edge:
  1. redirect = 1: pc = {redirect_pc[PC_W-1:2], 2'b00}, state = FLUSH. This applies in any state, including BOOT and FLUSH. A redirect while in FLUSH reloads pc and stays in FLUSH for one further cycle.
  2. Otherwise, if fetch_valid AND fetch_ready: pc = fetch_pred_target and fetch_count += 1.
  3. Otherwise: pc holds (stall). All outputs stay stable while fetch_valid = 1 and fetch_ready = 0. If btb_wr_en changes the BTB entry being read during a stall, the bundle may change; this is permitted only while not yet accepted.
- BTB write: on an edge with btb_wr_en = 1, the entry at btb_wr_pc's index gets valid = 1, tag = btb_wr_pc's tag, target = btb_wr_target. Any prior entry is overwritten (no associativity).
- A write and a read to the same index in the same cycle: the read sees the old contents; the new contents are visible from the next cycle. No bypass.
- btb_wr_en and redirect may be asserted together; both take effect.
- A fetch is not counted in the cycle redirect is high, even if fetch_ready = 1.
- The block never drives the predictor's update/valid inputs; those come from branch resolution.

Test Plan:
1. RESET_PC = 0x100; hold reset, release; fetch_ready = 1, pred_taken = 0 -> fetch_valid low for 1 cycle, then PCs 0x100, 0x104, 0x108; fetch_count = 3 after three accepts.
2. Stall: during RUN at pc 0x200, hold fetch_ready = 0 for 4 cycles -> fetch_pc stays 0x200, fetch_valid stays 1, fetch_count unchanged; releasing ready gives 0x204 next.
3. BTB write pc = 0x208, target = 0x400, then fetch reaches 0x208:
   - with pred_taken = 1 -> fetch_pred_taken = 1, fetch_pred_target = 0x400, next fetch_pc = 0x400.
   - with pred_taken = 0 -> next fetch_pc = 0x20C.
4. Aliasing with BTB_ENTRIES = 16: write 0x208 -> 0x400, then write 0x248 -> 0x800 (same index) -> a fetch at 0x208 misses (pred_taken ignored, next 0x20C); a fetch at 0x248 hits to 0x800.
5. Redirect redirect_pc = 0x1003 while fetch_ready = 1 at pc 0x300 -> fetch_valid = 0 that cycle, fetch_count not incremented, one bubble cycle, then fetch_pc = 0x1000. A second redirect during the bubble to 0x2000 -> one more bubble, then 0x2000.
6. Async reset asserted mid-stream between clock edges -> fetch_valid drops and pc = RESET_PC immediately. A previously written BTB entry no longer hits after reset.

Source files
------------

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch-stage next-PC sequencer with a direct-mapped BTB.
// Hands each fetched PC and its prediction to the instruction queue.
module fetch_pc_gen #(
   parameter int              PC_W        = 32,
   parameter int              BTB_ENTRIES = 16,
   parameter logic [PC_W-1:0] RESET_PC    = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic [PC_W-1:0] fetch_pc,
   input  logic            pred_taken,
   output logic            fetch_valid,
   input  logic            fetch_ready,
   output logic            fetch_pred_taken,
   output logic [PC_W-1:0] fetch_pred_target,
   input  logic            btb_wr_en,
   input  logic [PC_W-1:0] btb_wr_pc,
   input  logic [PC_W-1:0] btb_wr_target,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   output logic [31:0]     fetch_count
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = PC_W - IDX_W - 2;

   localparam logic [1:0] BOOT  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;

   localparam logic [PC_W-1:0] PC_RST = {RESET_PC[PC_W-1:2], 2'b00};

   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_nxt;
   logic [PC_W-1:0] seq_pc;
   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic            accept;
   logic            btb_hit;

   logic [BTB_ENTRIES-1:0] btb_valid;
   logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
   logic [PC_W-3:0]        btb_tgt [BTB_ENTRIES];

   logic [IDX_W-1:0] rd_idx;
   logic [TAG_W-1:0] rd_tag;
   logic [IDX_W-1:0] wr_idx;
   logic [TAG_W-1:0] wr_tag;

   // PC word-offset bits are forced to zero and never consumed
   logic unused_lsbs;
   assign unused_lsbs = ^{redirect_pc[1:0], btb_wr_pc[1:0], btb_wr_target[1:0]};

   assign rd_idx = pc[IDX_W+1:2];
   assign rd_tag = pc[PC_W-1:IDX_W+2];
   assign wr_idx = btb_wr_pc[IDX_W+1:2];
   assign wr_tag = btb_wr_pc[PC_W-1:IDX_W+2];

   assign btb_hit = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
   assign seq_pc  = pc + PC_W'(4);

   assign fetch_pc          = pc;
   assign fetch_valid       = (state == RUN) && !redirect;
   assign fetch_pred_taken  = btb_hit && pred_taken;
   assign fetch_pred_target = fetch_pred_taken ? {btb_tgt[rd_idx], 2'b00} : seq_pc;
   assign accept            = fetch_valid && fetch_ready;

   always_comb begin
      pc_nxt    = pc;
      state_nxt = state;
      unique case (1'b1)
         redirect: begin
            pc_nxt    = {redirect_pc[PC_W-1:2], 2'b00};
            state_nxt = FLUSH;
         end
         accept: begin
            pc_nxt    = fetch_pred_target;
            state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= PC_RST;
         state       <= BOOT;
         fetch_count <= '0;
      end else begin
         pc    <= pc_nxt;
         state <= state_nxt;
         if (accept)
            fetch_count <= fetch_count + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         btb_valid <= '0;
      else if (btb_wr_en)
         btb_valid[wr_idx] <= 1'b1;
   end

   // Payload arrays are qualified by btb_valid, so they carry no reset
   always_ff @(posedge clk) begin
      if (btb_wr_en) begin
         btb_tag[wr_idx] <= wr_tag;
         btb_tgt[wr_idx] <= btb_wr_target[PC_W-1:2];
      end
   end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed scenarios plus randomized traffic
// checked against a behavioural fetch/BTB model.
module tb_fetch_pc_gen;

   logic        clk;
   logic        reset;
   logic [31:0] fetch_pc;
   logic        pred_taken;
   logic        fetch_valid;
   logic        fetch_ready;
   logic        fetch_pred_taken;
   logic [31:0] fetch_pred_target;
   logic        btb_wr_en;
   logic [31:0] btb_wr_pc;
   logic [31:0] btb_wr_target;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] fetch_count;

   int total = 0;
   int bad   = 0;

   fetch_pc_gen #(
      .PC_W(32),
      .BTB_ENTRIES(16),
      .RESET_PC(32'h0000_0100)
   ) dut (
      .clk(clk),
      .reset(reset),
      .fetch_pc(fetch_pc),
      .pred_taken(pred_taken),
      .fetch_valid(fetch_valid),
      .fetch_ready(fetch_ready),
      .fetch_pred_taken(fetch_pred_taken),
      .fetch_pred_target(fetch_pred_target),
      .btb_wr_en(btb_wr_en),
      .btb_wr_pc(btb_wr_pc),
      .btb_wr_target(btb_wr_target),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .fetch_count(fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural model: whole written PCs are kept, hit is decided by arithmetic
   logic [31:0] m_pc;
   logic [31:0] m_count;
   bit          m_bub;
   bit          m_bv   [16];
   logic [31:0] m_bpc  [16];
   logic [31:0] m_btgt [16];

   function automatic int unsigned m_idx(input logic [31:0] a);
      return (a / 4) % 16;
   endfunction

   function automatic bit m_hit();
      int unsigned i;
      i = m_idx(m_pc);
      return m_bv[i] && ((m_bpc[i] / 64) == (m_pc / 64));
   endfunction

   function automatic bit m_ptk();
      return m_hit() && pred_taken;
   endfunction

   function automatic logic [31:0] m_tgt();
      if (m_ptk())
         return m_btgt[m_idx(m_pc)] & 32'hFFFF_FFFC;
      return m_pc + 32'd4;
   endfunction

   function automatic bit m_val();
      return !m_bub && !redirect;
   endfunction

   task automatic m_reset();
      m_pc    = 32'h0000_0100;
      m_count = 0;
      m_bub   = 1;
      for (int i = 0; i < 16; i++) m_bv[i] = 0;
   endtask

   task automatic tick();
      bit          v;
      logic [31:0] tg;
      int unsigned wi;
      v  = m_val();
      tg = m_tgt();
      @(posedge clk);
      if (redirect) begin
         m_pc  = redirect_pc & 32'hFFFF_FFFC;
         m_bub = 1;
      end else begin
         if (v && fetch_ready) begin
            m_pc    = tg;
            m_count = m_count + 1;
         end
         m_bub = 0;
      end
      if (btb_wr_en) begin
         wi         = m_idx(btb_wr_pc);
         m_bv[wi]   = 1;
         m_bpc[wi]  = btb_wr_pc;
         m_btgt[wi] = btb_wr_target;
      end
      #1;
   endtask

   task automatic idle();
      pred_taken    = 0;
      fetch_ready   = 1;
      btb_wr_en     = 0;
      btb_wr_pc     = 0;
      btb_wr_target = 0;
      redirect      = 0;
      redirect_pc   = 0;
   endtask

   task automatic go_to(input logic [31:0] a);
      redirect    = 1;
      redirect_pc = a;
      tick();
      redirect = 0;
      tick();
   endtask

   task automatic btb_write(input logic [31:0] a, input logic [31:0] t);
      fetch_ready   = 0;
      btb_wr_en     = 1;
      btb_wr_pc     = a;
      btb_wr_target = t;
      tick();
      btb_wr_en   = 0;
      fetch_ready = 1;
   endtask

   task automatic test_reset();
      idle();
      reset = 1;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (fetch_valid !== 1'b0 || fetch_pred_taken !== 1'b0) begin
         bad++;
         $display("FAIL reset_outs got v=%b pt=%b exp 0 0", fetch_valid, fetch_pred_taken);
      end
      total++;
      if (fetch_pc !== 32'h100 || fetch_count !== 0) begin
         bad++;
         $display("FAIL reset_state got pc=%h cnt=%0d exp 100 0", fetch_pc, fetch_count);
      end
      reset = 0;
      #1;
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc;
      total++;
      if (fetch_valid !== 1'b0) begin
         bad++;
         $display("FAIL boot_bubble got v=%b exp 0", fetch_valid);
      end
      tick();
      for (int k = 0; k < 3; k++) begin
         exp_pc = 32'h100 + 32'(4 * k);
         total++;
         if (fetch_pc !== exp_pc || fetch_valid !== 1'b1) begin
            bad++;
            $display("FAIL seq_pc%0d got pc=%h v=%b exp %h 1", k, fetch_pc, fetch_valid, exp_pc);
         end
         tick();
      end
      total++;
      if (fetch_count !== 32'd3) begin
         bad++;
         $display("FAIL seq_count got %0d exp 3", fetch_count);
      end
   endtask

   task automatic test_stall();
      logic [31:0] c0;
      go_to(32'h200);
      c0 = fetch_count;
      fetch_ready = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         total++;
         if (fetch_pc !== 32'h200 || fetch_valid !== 1'b1 || fetch_count !== c0) begin
            bad++;
            $display("FAIL stall%0d got pc=%h v=%b cnt=%0d exp 200 1 %0d",
                     k, fetch_pc, fetch_valid, fetch_count, c0);
         end
      end
      fetch_ready = 1;
      tick();
      total++;
      if (fetch_pc !== 32'h204 || fetch_count !== c0 + 1) begin
         bad++;
         $display("FAIL stall_release got pc=%h cnt=%0d exp 204 %0d", fetch_pc, fetch_count, c0 + 1);
      end
   endtask

   task automatic test_btb();
      btb_write(32'h208, 32'h400);
      go_to(32'h208);
      pred_taken = 1;
      #1;
      total++;
      if (fetch_pred_taken !== 1'b1 || fetch_pred_target !== 32'h400) begin
         bad++;
         $display("FAIL btb_hit got pt=%b tgt=%h exp 1 400", fetch_pred_taken, fetch_pred_target);
      end
      tick();
      total++;
      if (fetch_pc !== 32'h400) begin
         bad++;
         $display("FAIL btb_taken_pc got %h exp 400", fetch_pc);
      end
      pred_taken = 0;
      go_to(32'h208);
      tick();
      total++;
      if (fetch_pc !== 32'h20C) begin
         bad++;
         $display("FAIL btb_nt_pc got %h exp 20c", fetch_pc);
      end
   endtask

   task automatic test_alias();
      btb_write(32'h248, 32'h800);
      go_to(32'h208);
      pred_taken = 1;
      #1;
      total++;
      if (fetch_pred_taken !== 1'b0) begin
         bad++;
         $display("FAIL alias_miss got pt=%b exp 0", fetch_pred_taken);
      end
      tick();
      total++;
      if (fetch_pc !== 32'h20C) begin
         bad++;
         $display("FAIL alias_miss_pc got %h exp 20c", fetch_pc);
      end
      go_to(32'h248);
      tick();
      total++;
      if (fetch_pc !== 32'h800) begin
         bad++;
         $display("FAIL alias_hit_pc got %h exp 800", fetch_pc);
      end
      pred_taken = 0;
   endtask

   task automatic test_redirect();
      logic [31:0] c0;
      go_to(32'h300);
      c0          = fetch_count;
      redirect    = 1;
      redirect_pc = 32'h1003;
      #1;
      total++;
      if (fetch_valid !== 1'b0) begin
         bad++;
         $display("FAIL redir_squash got v=%b exp 0", fetch_valid);
      end
      tick();
      redirect = 0;
      #1;
      total++;
      if (fetch_count !== c0 || fetch_valid !== 1'b0 || fetch_pc !== 32'h1000) begin
         bad++;
         $display("FAIL redir_bubble got cnt=%0d v=%b pc=%h exp %0d 0 1000",
                  fetch_count, fetch_valid, fetch_pc, c0);
      end
      redirect    = 1;
      redirect_pc = 32'h2000;
      tick();
      redirect = 0;
      #1;
      total++;
      if (fetch_valid !== 1'b0 || fetch_pc !== 32'h2000) begin
         bad++;
         $display("FAIL redir_rebubble got v=%b pc=%h exp 0 2000", fetch_valid, fetch_pc);
      end
      tick();
      total++;
      if (fetch_valid !== 1'b1 || fetch_pc !== 32'h2000) begin
         bad++;
         $display("FAIL redir_resume got v=%b pc=%h exp 1 2000", fetch_valid, fetch_pc);
      end
   endtask

   task automatic test_async_reset();
      #2;
      reset = 1;
      m_reset();
      #1;
      total++;
      if (fetch_valid !== 1'b0 || fetch_pc !== 32'h100 || fetch_count !== 0) begin
         bad++;
         $display("FAIL async_reset got v=%b pc=%h cnt=%0d exp 0 100 0",
                  fetch_valid, fetch_pc, fetch_count);
      end
      @(posedge clk);
      #1;
      reset = 0;
      tick();
      go_to(32'h248);
      pred_taken = 1;
      #1;
      total++;
      if (fetch_pred_taken !== 1'b0) begin
         bad++;
         $display("FAIL reset_btb_clear got pt=%b exp 0", fetch_pred_taken);
      end
      tick();
      total++;
      if (fetch_pc !== 32'h24C) begin
         bad++;
         $display("FAIL reset_btb_pc got %h exp 24c", fetch_pc);
      end
      pred_taken = 0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         pred_taken    = $urandom_range(0, 1);
         fetch_ready   = ($urandom_range(0, 3) != 0);
         btb_wr_en     = ($urandom_range(0, 4) == 0);
         btb_wr_pc     = $urandom & 32'h0000_0FFF;
         btb_wr_target = $urandom & 32'h0000_0FFF;
         redirect      = ($urandom_range(0, 9) == 0);
         redirect_pc   = $urandom & 32'h0000_0FFF;
         #1;
         total++;
         if (fetch_pc !== m_pc || fetch_valid !== m_val() || fetch_count !== m_count
             || fetch_pred_taken !== m_ptk() || fetch_pred_target !== m_tgt()) begin
            bad++;
            $display("FAIL rand%0d got pc=%h v=%b pt=%b tgt=%h cnt=%0d exp %h %b %b %h %0d",
                     k, fetch_pc, fetch_valid, fetch_pred_taken, fetch_pred_target,
                     fetch_count, m_pc, m_val(), m_ptk(), m_tgt(), m_count);
         end
         tick();
      end
      idle();
   endtask

   initial begin
      reset = 1;
      idle();
      test_reset();
      test_sequential();
      test_stall();
      test_btb();
      test_alias();
      test_redirect();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
